// File: rtl/parity_nibble_seq.sv
// parity_nibble_seq
// -----------------
// Computes the parity of a DATA_W-bit word by streaming it, one nibble per
// cycle (least-significant nibble first), through an external 4-bit
// combinational parity encoder. The per-nibble results are accumulated, and
// the word parity is returned with an error flag against an expected bit.
//
// Optional build macro: PARITY_ODD_EN
//   undefined : out_par_o = XOR of all data bits (even parity)
//   defined   : out_par_o = ~XOR of all data bits (odd-parity bit)
//   out_err_o always compares out_par_o against the captured expected bit.
//
// Parameters:
//   DATA_W       word width; a multiple of 4 and >= 4 (NIB = DATA_W/4)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   producer has a word
//   in_ready_o   block can accept a word (only in IDLE and out of reset)
//   in_data_i    word to check
//   in_exp_par_i expected parity bit, sampled with in_data_i
//   nib_data_o   nibble driven to the external parity encoder
//   nib_par_i    encoder result (combinational XOR of nib_data_o)
//   out_valid_o  result available (DONE state)
//   out_ready_i  consumer accepts the result
//   out_par_o    computed word parity
//   out_err_o    out_par_o != captured expected parity
//   busy_o       high whenever the FSM is not IDLE
module parity_nibble_seq #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_exp_par_i,
  output logic [3:0]        nib_data_o,
  input  logic              nib_par_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_par_o,
  output logic              out_err_o,
  output logic              busy_o
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              exp_q, exp_d;
  logic              par_q, par_d;
  logic              err_q, err_d;

  // Parity of the whole word, valid in the last SCAN cycle only: the
  // accumulator holds the earlier nibbles, the encoder supplies the last one.
  logic word_par;
  logic word_res;

  assign word_par = acc_q ^ nib_par_i;
`ifdef PARITY_ODD_EN
  assign word_res = ~word_par;
`else
  assign word_res = word_par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    par_d   = par_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        // in_ready_o is high whenever the state register is clocked in IDLE
        if (in_valid_i) begin
          sr_d    = in_data_i;
          exp_d   = in_exp_par_i;
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d = acc_q ^ nib_par_i;
        sr_d  = sr_q >> 4;
        if (cnt_q == CNT_LAST) begin
          par_d   = word_res;
          err_d   = word_res ^ exp_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready is gated by rst_n so it is low for the whole reset interval, not
  // just after the first clock edge.
  assign in_ready_o  = rst_n && (state_q == IDLE);
  // Driven only from registers so the encoder input changes only at edges.
  assign nib_data_o  = (state_q == SCAN) ? sr_q[3:0] : 4'h0;
  assign out_valid_o = (state_q == DONE);
  assign out_par_o   = par_q;
  assign out_err_o   = err_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_parity_nibble_seq.sv
// Directed testbench for parity_nibble_seq (DATA_W = 16) with the external
// 4-bit parity encoder modelled as a continuous XOR. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_parity_nibble_seq;

  localparam int DATA_W = 16;
`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_exp_par;
  logic [3:0]        nib_data;
  logic              nib_par;
  logic              out_valid;
  logic              out_ready;
  logic              out_par;
  logic              out_err;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  parity_nibble_seq #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_exp_par_i (in_exp_par),
    .nib_data_o   (nib_data),
    .nib_par_i    (nib_par),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_par_o    (out_par),
    .out_err_o    (out_err),
    .busy_o       (busy)
  );

  // External combinational parity encoder
  assign nib_par = ^nib_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge with the block in IDLE; returns just
  // after a falling edge with the block back in IDLE. even_par is the
  // hand-computed XOR of the word; hold = extra DONE cycles with out_ready=0.
  task automatic run_word(input logic [15:0] data, input logic expb,
                          input logic [3:0] n0, input logic [3:0] n1,
                          input logic [3:0] n2, input logic [3:0] n3,
                          input logic even_par, input int hold);
    logic [3:0] nibs [4];
    logic p, e;
    nibs[0] = n0; nibs[1] = n1; nibs[2] = n2; nibs[3] = n3;
    p = even_par ^ ODD;
    e = p ^ expb;
    chk("idle_in_ready", {15'd0, in_ready}, 16'd1);
    in_valid   = 1'b1;
    in_data    = data;
    in_exp_par = expb;
    out_ready  = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      chk("scan_nib", {12'd0, nib_data}, {12'd0, nibs[i]});
      chk("scan_valid", {15'd0, out_valid}, 16'd0);
      chk("scan_busy", {15'd0, busy}, 16'd1);
      chk("scan_ready", {15'd0, in_ready}, 16'd0);
      @(negedge clk);
    end
    chk("done_valid", {15'd0, out_valid}, 16'd1);
    chk("done_par", {15'd0, out_par}, {15'd0, p});
    chk("done_err", {15'd0, out_err}, {15'd0, e});
    chk("done_ready", {15'd0, in_ready}, 16'd0);
    chk("done_nib", {12'd0, nib_data}, 16'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {15'd0, out_valid}, 16'd1);
      chk("hold_par", {15'd0, out_par}, {15'd0, p});
      chk("hold_err", {15'd0, out_err}, {15'd0, e});
      chk("hold_ready", {15'd0, in_ready}, 16'd0);
      chk("hold_busy", {15'd0, busy}, 16'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", {15'd0, out_valid}, 16'd0);
    chk("post_busy", {15'd0, busy}, 16'd0);
    chk("post_ready", {15'd0, in_ready}, 16'd1);
    chk("post_par_kept", {15'd0, out_par}, {15'd0, p});
    out_ready = 1'b0;
    $display("word data=%04h exp=%0b -> par=%0b err=%0b (want par=%0b err=%0b)",
             data, expb, out_par, out_err, p, e);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_exp_par = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_nib", {12'd0, nib_data}, 16'd0);
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_par", {15'd0, out_par}, 16'd0);
    chk("rst_err", {15'd0, out_err}, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);

    // Main function
    run_word(16'h0000, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0);
    run_word(16'h1234, 1'b1, 4'h4, 4'h3, 4'h2, 4'h1, 1'b1, 0);
    run_word(16'h8001, 1'b1, 4'h1, 4'h0, 4'h0, 4'h8, 1'b0, 0);
    run_word(16'hFFFF, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 0);

    // Backpressure: six DONE cycles with out_ready low
    run_word(16'h0001, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 5);

    // Reset during the second SCAN cycle
    in_valid   = 1'b1;
    in_data    = 16'h00F0;
    in_exp_par = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_nib0", {12'd0, nib_data}, 16'd0);
    @(negedge clk);
    chk("mid_nib1", {12'd0, nib_data}, 16'h000F);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk("mid_rst_nib", {12'd0, nib_data}, 16'd0);
    chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    chk("mid_rst_ready", {15'd0, in_ready}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale_valid", {15'd0, out_valid}, 16'd0);
      chk("no_stale_busy", {15'd0, busy}, 16'd0);
    end
    $display("reset mid-scan: in-flight word 00f0 discarded");
    run_word(16'h0003, 1'b0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 0);

`ifdef PARITY_ODD_EN
    run_word(16'h0000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 0);
    run_word(16'h0001, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
